// File: rtl/vram_arbiter_if.sv
// rtl/vram_arbiter_if.sv - CPU register port, display fetch and RAM-side signals of the VRAM arbiter
interface vram_arbiter_if #(
  parameter int ADDR_W = 11
);
  logic              cpu_wr;
  logic              mode;
  logic              rs;
  logic [7:0]        data;
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              blank;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_din;
  logic              ram_we;
  logic [7:0]        status_reg;
  logic [ADDR_W-1:0] wr_ptr;
  logic              fifo_empty;
  logic              fifo_full;
  logic              ovf;

  modport master (
    output cpu_wr, mode, rs, data, disp_req, disp_addr, blank,
    input  ram_addr, ram_din, ram_we, status_reg, wr_ptr, fifo_empty, fifo_full, ovf
  );

  modport slave (
    input  cpu_wr, mode, rs, data, disp_req, disp_addr, blank,
    output ram_addr, ram_din, ram_we, status_reg, wr_ptr, fifo_empty, fifo_full, ovf
  );
endinterface

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - name-table RAM arbiter: display fetch first, buffered CPU writes drained into idle slots
module vram_arbiter #(
  parameter int ADDR_W     = 11,
  parameter int TILES      = 1200,
  parameter int FIFO_DEPTH = 4,
  parameter int BLANK_ONLY = 0
) (
  input  logic           clk,
  input  logic           reset,
  vram_arbiter_if.slave  bus
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int ENT_W = ADDR_W + 8;
  localparam logic [ADDR_W-1:0] LAST_TILE = ADDR_W'(TILES - 1);
  localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);

  logic [ENT_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  head, tail;
  logic [PTR_W:0]    count, count_next;
  logic              empty_q, full_q;
  logic              push_req, push_ok, pop;
  logic [ENT_W-1:0]  head_ent;

  logic [ADDR_W-1:0] ptr_q;
  logic              phase;
  logic              ovf_q;
  logic [7:0]        status_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        din_q;
  logic              we_q;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    push_req = bus.cpu_wr && !bus.mode;
    pop      = !bus.disp_req && !empty_q && ((BLANK_ONLY == 0) || bus.blank);
    push_ok  = push_req && (!full_q || pop);
    head_ent = mem[head];
    case ({push_ok, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[tail] <= {ptr_q, bus.data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      if (push_ok) tail <= tail + PTR_W'(1);
      if (pop)     head <= head + PTR_W'(1);
      count   <= count_next;
      empty_q <= (count_next == '0);
      full_q  <= (count_next == FULL_CNT);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q    <= '0;
      phase    <= 1'b0;
      ovf_q    <= 1'b0;
      status_q <= '0;
    end else if (bus.cpu_wr) begin
      if (!bus.mode) begin
        if (push_ok) begin
          // Pointers loaded beyond the last tile also wrap to 0 on increment.
          ptr_q <= (ptr_q >= LAST_TILE) ? '0 : ptr_q + ADDR_W'(1);
        end else begin
          ovf_q <= 1'b1;
        end
      end else if (!bus.rs) begin
        status_q <= bus.data;
        phase    <= 1'b0;
        ovf_q    <= 1'b0;
      end else if (!phase) begin
        ptr_q[7:0] <= bus.data;
        phase      <= 1'b1;
      end else begin
        ptr_q[ADDR_W-1:8] <= bus.data[ADDR_W-9:0];
        phase             <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
      din_q  <= '0;
      we_q   <= 1'b0;
    end else if (bus.disp_req) begin
      addr_q <= bus.disp_addr;
      we_q   <= 1'b0;
    end else if (pop) begin
      addr_q <= head_ent[ENT_W-1:8];
      din_q  <= head_ent[7:0];
      we_q   <= 1'b1;
    end else begin
      we_q   <= 1'b0;
    end
  end

  assign bus.ram_addr   = addr_q;
  assign bus.ram_din    = din_q;
  assign bus.ram_we     = we_q;
  assign bus.status_reg = status_q;
  assign bus.wr_ptr     = ptr_q;
  assign bus.fifo_empty = empty_q;
  assign bus.fifo_full  = full_q;
  assign bus.ovf        = ovf_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - directed bench for vram_arbiter, free-draining and blank-only instances
module tb_vram_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  vram_arbiter_if #(.ADDR_W(11)) a ();
  vram_arbiter_if #(.ADDR_W(11)) b ();

  vram_arbiter #(.ADDR_W(11), .TILES(1200), .FIFO_DEPTH(4), .BLANK_ONLY(0)) u0 (
    .clk(clk), .reset(reset), .bus(a)
  );
  vram_arbiter #(.ADDR_W(11), .TILES(1200), .FIFO_DEPTH(4), .BLANK_ONLY(1)) u1 (
    .clk(clk), .reset(reset), .bus(b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wr_a(input logic m, input logic r, input logic [7:0] d);
    a.cpu_wr = 1'b1;
    a.mode   = m;
    a.rs     = r;
    a.data   = d;
    step();
    a.cpu_wr = 1'b0;
  endtask

  initial begin
    a.cpu_wr = 0; a.mode = 0; a.rs = 0; a.data = 0; a.disp_req = 0; a.disp_addr = 0; a.blank = 0;
    b.cpu_wr = 0; b.mode = 0; b.rs = 0; b.data = 0; b.disp_req = 0; b.disp_addr = 0; b.blank = 0;
    step();
    step();
    reset = 1'b0;

    chk("rst_we", a.ram_we, 0);
    chk("rst_addr", a.ram_addr, 0);
    chk("rst_din", a.ram_din, 0);
    chk("rst_status", a.status_reg, 0);
    chk("rst_ptr", a.wr_ptr, 0);
    chk("rst_empty", a.fifo_empty, 1);
    chk("rst_full", a.fifo_full, 0);
    chk("rst_ovf", a.ovf, 0);

    // 1: pointer 256, two data bytes
    wr_a(1, 1, 8'h00);
    wr_a(1, 1, 8'h01);
    chk("t1_ptr", a.wr_ptr, 256);
    wr_a(0, 0, 8'h41);
    chk("t1_we0", a.ram_we, 0);
    chk("t1_nempty", a.fifo_empty, 0);
    wr_a(0, 0, 8'h42);
    chk("t1_we1", a.ram_we, 1);
    chk("t1_addr1", a.ram_addr, 256);
    chk("t1_din1", a.ram_din, 8'h41);
    step();
    chk("t1_we2", a.ram_we, 1);
    chk("t1_addr2", a.ram_addr, 257);
    chk("t1_din2", a.ram_din, 8'h42);
    chk("t1_ptr2", a.wr_ptr, 258);
    step();
    chk("t1_we_off", a.ram_we, 0);
    chk("t1_empty", a.fifo_empty, 1);

    // 2: wrap at last tile
    wr_a(1, 1, 8'hAF);
    wr_a(1, 1, 8'h04);
    chk("t2_ptr", a.wr_ptr, 1199);
    wr_a(0, 0, 8'h10);
    wr_a(0, 0, 8'h11);
    chk("t2_addr1", a.ram_addr, 1199);
    chk("t2_din1", a.ram_din, 8'h10);
    wr_a(0, 0, 8'h12);
    chk("t2_addr2", a.ram_addr, 0);
    chk("t2_din2", a.ram_din, 8'h11);
    step();
    chk("t2_addr3", a.ram_addr, 1);
    chk("t2_din3", a.ram_din, 8'h12);
    chk("t2_we3", a.ram_we, 1);
    chk("t2_ptr2", a.wr_ptr, 2);
    step();
    chk("t2_we_off", a.ram_we, 0);

    // 3: display holds the RAM, FIFO fills and overflows, then drains in order
    a.disp_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a.disp_addr = 11'(100 + i);
      a.cpu_wr    = (i >= 2 && i <= 6);
      a.mode      = 1'b0;
      a.data      = 8'(8'h20 + i - 2);
      step();
      chk($sformatf("t3_addr%0d", i), a.ram_addr, 100 + i);
      chk($sformatf("t3_we%0d", i), a.ram_we, 0);
    end
    a.cpu_wr = 1'b0;
    chk("t3_full", a.fifo_full, 1);
    chk("t3_ovf", a.ovf, 1);
    chk("t3_ptr", a.wr_ptr, 6);
    a.disp_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("t3_dwe%0d", k), a.ram_we, 1);
      chk($sformatf("t3_daddr%0d", k), a.ram_addr, 2 + k);
      chk($sformatf("t3_ddin%0d", k), a.ram_din, 8'h20 + k);
    end
    step();
    chk("t3_we_off", a.ram_we, 0);
    chk("t3_empty", a.fifo_empty, 1);

    // 4: status write clears ovf and the address-byte phase
    wr_a(1, 0, 8'hC0);
    chk("t4_status", a.status_reg, 8'hC0);
    chk("t4_ovf", a.ovf, 0);
    wr_a(1, 1, 8'h33);
    chk("t4_lo", a.wr_ptr, 11'h033);
    wr_a(1, 0, 8'h80);
    wr_a(1, 1, 8'h05);
    chk("t4_phase", a.wr_ptr, 11'h005);
    chk("t4_status2", a.status_reg, 8'h80);
    wr_a(1, 1, 8'h02);
    chk("t4_hi", a.wr_ptr, 11'h205);

    // 5: blank-only instance waits for blank
    b.cpu_wr = 1'b1; b.mode = 1'b0; b.data = 8'h55;
    step();
    b.cpu_wr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("t5_hold_we%0d", k), b.ram_we, 0);
      chk($sformatf("t5_hold_ne%0d", k), b.fifo_empty, 0);
    end
    b.blank = 1'b1;
    step();
    chk("t5_we", b.ram_we, 1);
    chk("t5_addr", b.ram_addr, 0);
    chk("t5_din", b.ram_din, 8'h55);
    step();
    chk("t5_we_off", b.ram_we, 0);
    chk("t5_empty", b.fifo_empty, 1);

    // 6: reset discards pending entries
    a.disp_req = 1'b1;
    wr_a(0, 0, 8'h61);
    wr_a(0, 0, 8'h62);
    wr_a(0, 0, 8'h63);
    chk("t6_pending", a.fifo_empty, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    a.disp_req = 1'b0;
    chk("t6_we", a.ram_we, 0);
    chk("t6_empty", a.fifo_empty, 1);
    chk("t6_ptr", a.wr_ptr, 0);
    chk("t6_status", a.status_reg, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("t6_quiet%0d", k), a.ram_we, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
Sequences all accesses to the 1200-cell character name-table RAM (RAM_sync, 11-bit address, 8-bit data) for the text display.
- Accepts CPU byte writes on the existing cpu_we/mode/rs/data register interface, now sampled synchronously.
- Buffers data writes in a small FIFO and drains them into RAM in slots the display fetch does not use.
- Display fetch always has priority.
- Owns the status register and the auto-incrementing VRAM write pointer.

Parameters:
ADDR_W, 11, RAM address width
TILES, 1200, number of name-table cells (40x30); write pointer wraps at TILES-1
FIFO_DEPTH, 4, CPU write buffer entries; power of two, >=2
BLANK_ONLY, 0, if 1, FIFO drains only while blank=1

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cpu_wr  in  1  one-cycle CPU write strobe, sampled on posedge clk
mode  in  1  0 = VRAM data write, 1 = register write
rs  in  1  register select when mode=1: 0 = status, 1 = address byte
data  in  8  CPU write data
disp_req  in  1  display fetch request this cycle
disp_addr  in  ADDR_W  display fetch address
blank  in  1  1 outside active display area
ram_addr  out  ADDR_W  registered RAM address
ram_din  out  8  registered RAM write data
ram_we  out  1  registered RAM write enable
status_reg  out  8  bit7 display enable, bit6 interrupt enable, others free
wr_ptr  out  ADDR_W  current VRAM write pointer
fifo_empty  out  1  write FIFO empty
fifo_full  out  1  write FIFO full
ovf  out  1  sticky: a data write was dropped

Behaviour:
- Reset: ram_addr=0, ram_din=0, ram_we=0, status_reg=0, wr_ptr=0, address-byte phase=0, FIFO emptied (fifo_empty=1, fifo_full=0), ovf=0.
- Reset mid-operation: pending FIFO entries are discarded. ram_we is 0 after the reset edge.
- CPU decode (cpu_wr=1 only; otherwise no register change):
  - mode=0: push {wr_ptr, data}. wr_ptr <= 0 if wr_ptr >= TILES-1, else wr_ptr+1.
  - mode=0 with FIFO full and no pop in the same cycle: entry dropped, wr_ptr unchanged, ovf <= 1.
  - mode=1, rs=0: status_reg <= data. Address-byte phase <= 0. ovf <= 0.
  - mode=1, rs=1, phase=0: wr_ptr[7:0] <= data, phase <= 1.
  - mode=1, rs=1, phase=1: wr_ptr[10:8] <= data[2:0], phase <= 0.
  - Out-of-range pointer values (>=TILES) are stored as loaded. The next increment wraps them to 0.
- Arbiter (evaluated every cycle, outputs registered):
  - disp_req=1: ram_addr <= disp_addr, ram_we <= 0. The FIFO is not popped.
  - Else, if FIFO non-empty and (BLANK_ONLY=0 or blank=1): pop the head; ram_addr <= head.addr, ram_din <= head.data, ram_we <= 1.
  - Else: ram_we <= 0. ram_addr and ram_din hold.
- Latency:
  - Display: disp_req at edge t gives ram_addr at t+1; RAM data is valid at t+2.
  - CPU write into an empty FIFO at edge t: earliest ram_we at t+2 (push at t, pop/issue at t+1).
- ram_we is high for exactly one cycle per popped entry. Back-to-back pops give consecutive ram_we cycles.
- FIFO:
  - Simultaneous push and pop is legal in all states, including full; count is unchanged.
  - fifo_full and fifo_empty are registered flags matching the occupancy after each edge.
- Ordering: RAM writes occur in push order. Every accepted byte is written exactly once.

Test Plan:
1. Reset, then load address 0x00,0x01 (pointer 256), then data writes 0x41,0x42 with disp_req=0 -> ram_we pulses write 0x41@256 and 0x42@257; wr_ptr=258.
2. Pointer set to 1199, three data writes -> RAM writes at 1199, 0, 1; wr_ptr=2.
3. disp_req held 1 for 20 cycles while 4 data writes are pushed -> no ram_we, ram_addr tracks disp_addr at +1 cycle, fifo_full=1. 5th write -> ovf=1, wr_ptr unchanged. disp_req drops -> 4 consecutive ram_we cycles in order.
4. Status write 0xC0 -> status_reg=0xC0, ovf cleared. Address low write then status write then address write 0x05 -> 0x05 lands in the low byte (phase reset).
5. BLANK_ONLY=1, blank=0, disp_req=0, one data write -> no ram_we until blank=1, then ram_we one cycle later.
6. Reset asserted with 3 FIFO entries pending -> next cycle ram_we=0, fifo_empty=1, wr_ptr=0, status_reg=0, and no further writes are issued.
